// File: rtl/kb_pkg.sv
// Shared constants and the frame FSM state type for the PS/2 keyboard decoder.
package kb_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam int KB_SHIFT_BIT = 0;
  localparam int KB_CAPS_BIT  = 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  function automatic logic is_shift(input logic [7:0] b);
    return (b == SC_LSHIFT) || (b == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_kb_decoder_if.sv
// PS/2 pins in, decoded key state out; rx_state exposes the frame FSM for observation.
interface ps2_kb_decoder_if;
  import kb_pkg::*;

  logic         ps2_clk;
  logic         ps2_data;
  logic [7:0]   scancode;
  logic [1:0]   kb_state;
  logic         key_valid;
  logic         key_ext;
  logic         frame_err;
  frame_state_e rx_state;

  modport master (
    input  ps2_clk, ps2_data,
    output scancode, kb_state, key_valid, key_ext, frame_err, rx_state
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scancode, kb_state, key_valid, key_ext, frame_err, rx_state
  );

endinterface

// File: rtl/ps2_kb_decoder_frame_rx.sv
// Pin synchronisers, 11-bit PS/2 frame FSM and mid-frame timeout.
module ps2_frame_rx
  import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic [7:0]   rx_byte,
    output logic         byte_ok,
    output logic         err,
    output logic         tmo,
    output frame_state_e state_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    frame_state_e           state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   fall, data_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        fall       = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        data_bit   = dat_sync_q[SYNC_STAGES-1];
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_ok    = 1'b0;
        err        = 1'b0;
        tmo        = 1'b0;
        cnt_d      = (state_q == IDLE || fall) ? '0 : cnt_q + 1'b1;
        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d   = {data_bit, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_bit;
                    state_d = STOP;
                end
                STOP: begin
                    // Odd parity across data and parity bit, plus a high stop bit.
                    if (data_bit && (^{shreg_q, par_q})) byte_ok = 1'b1;
                    else err = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && cnt_q == TMO_LAST) begin
            state_d = IDLE;
            tmo     = 1'b1;
            cnt_d   = '0;
        end
    end

    assign rx_byte = shreg_q;
    assign state_o = state_q;

endmodule

// File: rtl/ps2_kb_decoder.sv
// Decodes PS/2 make/break/extended byte streams into held scancode and modifier state.
module ps2_kb_decoder
  import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    ps2_kb_decoder_if.master bus
);

    logic [7:0] rx_byte;
    logic       byte_ok, err, tmo;

    logic [7:0] scancode_q, scancode_d;
    logic [1:0] kb_state_q, kb_state_d;
    logic       key_valid_q, key_valid_d;
    logic       key_ext_q, key_ext_d;
    logic       frame_err_q, frame_err_d;
    logic       break_pend_q, break_pend_d;
    logic       ext_pend_q, ext_pend_d;
    logic       same_key;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk_i (bus.ps2_clk),
        .ps2_data_i(bus.ps2_data),
        .rx_byte   (rx_byte),
        .byte_ok   (byte_ok),
        .err       (err),
        .tmo       (tmo),
        .state_o   (bus.rx_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scancode_q   <= '0;
            kb_state_q   <= '0;
            key_valid_q  <= 1'b0;
            key_ext_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else begin
            scancode_q   <= scancode_d;
            kb_state_q   <= kb_state_d;
            key_valid_q  <= key_valid_d;
            key_ext_q    <= key_ext_d;
            frame_err_q  <= frame_err_d;
            break_pend_q <= break_pend_d;
            ext_pend_q   <= ext_pend_d;
        end
    end

    always_comb begin
        scancode_d   = scancode_q;
        kb_state_d   = kb_state_q;
        key_valid_d  = 1'b0;
        key_ext_d    = key_ext_q;
        frame_err_d  = err;
        break_pend_d = break_pend_q;
        ext_pend_d   = ext_pend_q;
        // A key matches the held one only if its E0 prefix state matches too.
        same_key     = (rx_byte == scancode_q) && (ext_pend_q == key_ext_q);
        if (err || tmo) begin
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
        end else if (byte_ok) begin
            if (rx_byte == SC_BREAK) begin
                break_pend_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_pend_d = 1'b1;
            end else if (break_pend_q) begin
                if (!ext_pend_q && is_shift(rx_byte)) kb_state_d[KB_SHIFT_BIT] = 1'b0;
                if (same_key) begin
                    scancode_d = '0;
                    key_ext_d  = 1'b0;
                end
                break_pend_d = 1'b0;
                ext_pend_d   = 1'b0;
            end else begin
                key_valid_d = 1'b1;
                if (!same_key) begin
                    scancode_d = rx_byte;
                    key_ext_d  = ext_pend_q;
                    if (!ext_pend_q && is_shift(rx_byte)) kb_state_d[KB_SHIFT_BIT] = 1'b1;
                    if (!ext_pend_q && rx_byte == SC_CAPS)
                        kb_state_d[KB_CAPS_BIT] = ~kb_state_q[KB_CAPS_BIT];
                end
                ext_pend_d = 1'b0;
            end
        end
    end

    assign bus.scancode  = scancode_q;
    assign bus.kb_state  = kb_state_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.frame_err = frame_err_q;

endmodule
